// File: rtl/keccak_pkg.sv
// Shared constants, mode encodings, state type and per-mode geometry for the
// Keccak squeeze streamer.
package keccak_pkg;

   localparam int DATA_SIZE         = 64;
   localparam int VALID_BYTES_WIDTH = 4;
   localparam int MAX_RATE_BITS     = 1344;
   localparam int LANE_IDX_WIDTH    = 5;

   localparam logic [2:0] MODE_SHA3_224 = 3'd0;
   localparam logic [2:0] MODE_SHA3_256 = 3'd1;
   localparam logic [2:0] MODE_SHA3_384 = 3'd2;
   localparam logic [2:0] MODE_SHA3_512 = 3'd3;
   localparam logic [2:0] MODE_SHAKE128 = 3'd4;
   localparam logic [2:0] MODE_SHAKE256 = 3'd5;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_BLOCK = 2'd1,
      STREAM     = 2'd2,
      REQ_PERM   = 2'd3
   } sq_state_t;

   function automatic logic [LANE_IDX_WIDTH-1:0] rate_lanes(input logic [2:0] mode);
      case (mode)
         MODE_SHA3_224: return 5'd18;
         MODE_SHA3_256: return 5'd17;
         MODE_SHA3_384: return 5'd13;
         MODE_SHA3_512: return 5'd9;
         MODE_SHAKE128: return 5'd21;
         MODE_SHAKE256: return 5'd17;
         default:       return 5'd0;
      endcase
   endfunction

   function automatic logic [15:0] digest_bytes(input logic [2:0] mode);
      case (mode)
         MODE_SHA3_224: return 16'd28;
         MODE_SHA3_256: return 16'd32;
         MODE_SHA3_384: return 16'd48;
         MODE_SHA3_512: return 16'd64;
         default:       return 16'd0;
      endcase
   endfunction

   function automatic logic is_shake(input logic [2:0] mode);
      return (mode == MODE_SHAKE128) || (mode == MODE_SHAKE256);
   endfunction

endpackage

// File: rtl/keccak_squeeze_streamer.sv
// Streams the rate portion of permuted Keccak states out as lane-wide beats,
// requesting further permutations until the requested byte count is delivered.
//
// state      | meaning
// IDLE       | no job; waits for a start with a usable mode/length
// WAIT_BLOCK | job active; waits for the core to present a permuted block
// STREAM     | emitting lanes of the held block to the downstream sink
// REQ_PERM   | rate exhausted with bytes still owed; one-cycle permutation request
module keccak_squeeze_streamer #(
   parameter int DATA_SIZE     = keccak_pkg::DATA_SIZE,
   parameter int MAX_RATE_BITS = keccak_pkg::MAX_RATE_BITS
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start_i,
   input  logic [2:0]                             keccak_mode_i,
   input  logic [15:0]                            out_len_i,
   input  logic [MAX_RATE_BITS-1:0]               block_i,
   input  logic                                   block_valid_i,
   output logic                                   block_ready_o,
   output logic                                   perm_req_o,
   output logic [DATA_SIZE-1:0]                   t_data_o,
   output logic                                   t_valid_o,
   output logic                                   t_last_o,
   output logic [keccak_pkg::VALID_BYTES_WIDTH-1:0] t_valid_bytes_o,
   input  logic                                   t_ready_i,
   output logic                                   busy_o
);
   import keccak_pkg::*;

   localparam int LANES      = MAX_RATE_BITS / DATA_SIZE;
   localparam int LANE_BYTES = DATA_SIZE / 8;

   sq_state_t                    state, state_nxt;
   logic [2:0]                   mode_q;
   logic [15:0]                  remaining;
   logic [LANE_IDX_WIDTH-1:0]    lane_idx;
   logic [MAX_RATE_BITS-1:0]     block_q;
   logic [DATA_SIZE-1:0]         data_q;

   logic                         start_ok;
   logic [15:0]                  load_len;
   logic                         last_beat;
   logic                         rate_end;
   logic [VALID_BYTES_WIDTH-1:0] beat_bytes;
   logic [VALID_BYTES_WIDTH-1:0] next_bytes;
   logic [15:0]                  rem_nxt;
   logic [LANE_IDX_WIDTH-1:0]    lane_nxt;
   logic [DATA_SIZE-1:0]         next_lane_word;

   function automatic logic [VALID_BYTES_WIDTH-1:0] clip_bytes(input logic [15:0] rem);
      if (rem > 16'(LANE_BYTES)) return VALID_BYTES_WIDTH'(LANE_BYTES);
      return rem[VALID_BYTES_WIDTH-1:0];
   endfunction

   function automatic logic [DATA_SIZE-1:0] mask_bytes(input logic [DATA_SIZE-1:0]         word,
                                                       input logic [VALID_BYTES_WIDTH-1:0] n);
      logic [DATA_SIZE-1:0] res;
      res = '0;
      for (int b = 0; b < LANE_BYTES; b++) begin
         if (b < int'(n)) res[b*8 +: 8] = word[b*8 +: 8];
      end
      return res;
   endfunction

   always_comb begin
      start_ok = 1'b0;
      load_len = '0;
      if (keccak_mode_i <= MODE_SHAKE256) begin
         load_len = is_shake(keccak_mode_i) ? out_len_i : digest_bytes(keccak_mode_i);
         start_ok = start_i && (load_len != 16'd0);
      end
   end

   assign beat_bytes = clip_bytes(remaining);
   assign last_beat  = (remaining <= 16'(LANE_BYTES));
   assign rem_nxt    = remaining - 16'(beat_bytes);
   assign next_bytes = clip_bytes(rem_nxt);
   assign lane_nxt   = lane_idx + 1'b1;
   assign rate_end   = (lane_idx == rate_lanes(mode_q) - 1'b1);

   // Lane mux feeding the output register; lanes past the buffer read as zero.
   always_comb begin
      next_lane_word = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_nxt == LANE_IDX_WIDTH'(i)) next_lane_word = block_q[i*DATA_SIZE +: DATA_SIZE];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      block_ready_o = 1'b0;
      perm_req_o    = 1'b0;
      t_valid_o     = 1'b0;
      busy_o        = 1'b1;
      case (state)
         IDLE: begin
            busy_o = 1'b0;
            if (start_ok) state_nxt = WAIT_BLOCK;
         end
         WAIT_BLOCK: begin
            block_ready_o = 1'b1;
            if (block_valid_i) state_nxt = STREAM;
         end
         STREAM: begin
            t_valid_o = 1'b1;
            if (t_ready_i) begin
               if (last_beat)     state_nxt = IDLE;
               else if (rate_end) state_nxt = REQ_PERM;
            end
         end
         REQ_PERM: begin
            perm_req_o = 1'b1;
            state_nxt  = WAIT_BLOCK;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign t_last_o        = t_valid_o && last_beat;
   assign t_valid_bytes_o = t_valid_o ? beat_bytes : '0;
   assign t_data_o        = t_valid_o ? data_q : '0;

   // data_q always holds the already-masked word for the beat being offered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= '0;
         remaining <= '0;
         lane_idx  <= '0;
         block_q   <= '0;
         data_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  mode_q    <= keccak_mode_i;
                  remaining <= load_len;
               end
            end
            WAIT_BLOCK: begin
               if (block_valid_i) begin
                  block_q  <= block_i;
                  lane_idx <= '0;
                  data_q   <= mask_bytes(block_i[DATA_SIZE-1:0], beat_bytes);
               end
            end
            STREAM: begin
               if (t_ready_i) begin
                  remaining <= rem_nxt;
                  lane_idx  <= lane_nxt;
                  data_q    <= mask_bytes(next_lane_word, next_bytes);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_squeeze_streamer.sv
// Directed and randomized squeeze jobs checked against a byte-stream reference
// model built from the per-mode rate and digest lengths.
module tb_keccak_squeeze_streamer;
   localparam int DW = 64;
   localparam int RB = 1344;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [2:0]    keccak_mode_i;
   logic [15:0]   out_len_i;
   logic [RB-1:0] block_i;
   logic          block_valid_i;
   logic          block_ready_o;
   logic          perm_req_o;
   logic [DW-1:0] t_data_o;
   logic          t_valid_o;
   logic          t_last_o;
   logic [3:0]    t_valid_bytes_o;
   logic          t_ready_i;
   logic          busy_o;

   int n_asserts = 0;
   int n_fail    = 0;
   logic [RB-1:0] blocks [4];

   keccak_squeeze_streamer #(.DATA_SIZE(DW), .MAX_RATE_BITS(RB)) dut (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start_i),
      .keccak_mode_i   (keccak_mode_i),
      .out_len_i       (out_len_i),
      .block_i         (block_i),
      .block_valid_i   (block_valid_i),
      .block_ready_o   (block_ready_o),
      .perm_req_o      (perm_req_o),
      .t_data_o        (t_data_o),
      .t_valid_o       (t_valid_o),
      .t_last_o        (t_last_o),
      .t_valid_bytes_o (t_valid_bytes_o),
      .t_ready_i       (t_ready_i),
      .busy_o          (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_lanes(input int m);
      case (m)
         0: return 18;
         1: return 17;
         2: return 13;
         3: return 9;
         4: return 21;
         default: return 17;
      endcase
   endfunction

   function automatic int ref_total(input int m, input int len);
      case (m)
         0: return 28;
         1: return 32;
         2: return 48;
         3: return 64;
         default: return len;
      endcase
   endfunction

   // Byte n of the squeezed output stream: blocks concatenated, rate bytes each.
   function automatic logic [7:0] ref_byte(input int m, input int n);
      int rate_b;
      rate_b = ref_lanes(m) * 8;
      return blocks[n / rate_b][(n % rate_b)*8 +: 8];
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_data"},   t_data_o, 64'd0);
      check({tag, "_valid"},  {63'd0, t_valid_o}, 64'd0);
      check({tag, "_last"},   {63'd0, t_last_o}, 64'd0);
      check({tag, "_vbytes"}, {60'd0, t_valid_bytes_o}, 64'd0);
      check({tag, "_bready"}, {63'd0, block_ready_o}, 64'd0);
      check({tag, "_perm"},   {63'd0, perm_req_o}, 64'd0);
      check({tag, "_busy"},   {63'd0, busy_o}, 64'd0);
   endtask

   task automatic run_job(input int m, input int len, input bit rnd_ready,
                          input int abort_beat, input bit poke_start);
      int total;
      int nblk;
      int nbeats;
      int beat;
      int blk;
      int perms;
      int rem;
      bit done;
      bit acc_pending;
      bit stalled;
      logic [63:0] exp_data;
      logic [3:0]  exp_vb;
      logic [63:0] prev_data;
      logic [3:0]  prev_vb;
      logic        prev_last;
      total  = ref_total(m, len);
      nblk   = (total + ref_lanes(m)*8 - 1) / (ref_lanes(m)*8);
      nbeats = (total + 7) / 8;
      beat = 0; blk = 0; perms = 0;
      done = 0; acc_pending = 0; stalled = 0;
      prev_data = '0; prev_vb = '0; prev_last = 1'b0;
      for (int i = 0; i < nblk; i++)
         for (int w = 0; w < RB/32; w++) blocks[i][w*32 +: 32] = $urandom();

      @(negedge clk);
      start_i = 1'b1; keccak_mode_i = 3'(m); out_len_i = 16'(len);
      @(negedge clk);
      start_i = 1'b0;
      check("busy_after_start", {63'd0, busy_o}, 64'd1);

      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         start_i = 1'b0;
         if (acc_pending) check("valid_latency", {63'd0, t_valid_o}, 64'd1);
         acc_pending = 0;
         if (perm_req_o) perms++;
         if (block_ready_o && blk < nblk) begin
            block_valid_i = 1'b1; block_i = blocks[blk]; blk++; acc_pending = 1;
         end else begin
            block_valid_i = 1'b0;
         end
         if (t_valid_o) begin
            if (beat == abort_beat) begin
               rst = 1'b1; block_valid_i = 1'b0;
               #1;
               check_all_zero("reset_midjob");
               @(negedge clk);
               rst = 1'b0;
               check("idle_after_abort", {63'd0, busy_o}, 64'd0);
               return;
            end
            if (stalled) begin
               check("hold_data",   t_data_o, prev_data);
               check("hold_vbytes", {60'd0, t_valid_bytes_o}, {60'd0, prev_vb});
               check("hold_last",   {63'd0, t_last_o}, {63'd0, prev_last});
            end
            t_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled   = !t_ready_i;
            prev_data = t_data_o; prev_vb = t_valid_bytes_o; prev_last = t_last_o;
            if (t_ready_i) begin
               rem = total - beat*8;
               exp_vb = (rem > 8) ? 4'd8 : 4'(rem);
               exp_data = '0;
               for (int j = 0; j < 8; j++)
                  if (j < int'(exp_vb)) exp_data[j*8 +: 8] = ref_byte(m, beat*8 + j);
               check("beat_data",   t_data_o, exp_data);
               check("beat_vbytes", {60'd0, t_valid_bytes_o}, {60'd0, exp_vb});
               check("beat_last",   {63'd0, t_last_o}, {63'd0, (rem <= 8)});
               beat++;
               if (t_last_o) done = 1;
            end
            if (poke_start && beat == 1) begin
               start_i = 1'b1; keccak_mode_i = 3'd4; out_len_i = 16'd9;
            end
         end else begin
            t_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 0;
         end
         @(negedge clk);
      end
      start_i = 1'b0;
      block_valid_i = 1'b0;
      check("job_done",     {63'd0, done}, 64'd1);
      check("valid_low_after_last", {63'd0, t_valid_o}, 64'd0);
      check("idle_after_last",      {63'd0, busy_o}, 64'd0);
      check("beat_count",   64'(beat), 64'(nbeats));
      check("perm_pulses",  64'(perms), 64'(nblk - 1));
      check("blocks_used",  64'(blk), 64'(nblk));
   endtask

   task automatic try_ignored_start(input int m, input int len);
      @(negedge clk);
      start_i = 1'b1; keccak_mode_i = 3'(m); out_len_i = 16'(len);
      @(negedge clk);
      start_i = 1'b0;
      check("ignored_start_busy",   {63'd0, busy_o}, 64'd0);
      check("ignored_start_bready", {63'd0, block_ready_o}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; keccak_mode_i = '0; out_len_i = '0;
      block_i = '0; block_valid_i = 1'b0; t_ready_i = 1'b1;
      #12;
      check_all_zero("in_reset");
      @(negedge clk);
      rst = 1'b0;

      run_job(1, 0, 0, -1, 0);     // SHA3-256
      run_job(0, 0, 0, -1, 0);     // SHA3-224, short final beat
      run_job(4, 200, 0, -1, 0);   // SHAKE128 across two blocks
      run_job(4, 168, 0, -1, 0);   // SHAKE128 ending exactly on the rate
      run_job(5, 100, 1, -1, 0);   // SHAKE256 with backpressure
      run_job(3, 0, 0, 1, 0);      // SHA3-512 reset on beat 2
      run_job(3, 0, 0, -1, 0);
      run_job(1, 0, 1, -1, 1);     // start pulsed while busy
      try_ignored_start(4, 0);
      try_ignored_start(5, 0);
      try_ignored_start(6, 40);
      try_ignored_start(7, 40);
      run_job(2, 0, 1, -1, 0);
      for (int k = 0; k < 6; k++)
         run_job($urandom_range(0, 5), $urandom_range(1, 400), 1, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
